// File: rtl/pkt_pkg.sv
// Shared constants and types for the packet receive framer.
package pkt_pkg;

  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam logic [7:0] KILL_CMD = 8'hFF;
  localparam int unsigned DEF_PAY_W = 16;

  typedef enum logic {IDLE, ASSM} rx_state_t;

  typedef struct packed {
    logic [7:0]           cmd;
    logic [DEF_PAY_W-1:0] data;
  } pkt_entry_t;

endpackage

// File: rtl/pkt_rx_framer_if.sv
// Byte-in / frame-out bus of the packet framer, plus its status outputs.
interface pkt_rx_framer_if #(
  parameter int unsigned PAY_W = 16
) ();

  logic [7:0]       veh_id;
  logic [7:0]       rx_byte;
  logic             rx_valid;
  logic             rx_ready;
  logic [7:0]       out_cmd;
  logic [PAY_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             kill;
  logic [7:0]       drop_cnt;
  logic [7:0]       tmo_cnt;

  modport master (
    output veh_id, rx_byte, rx_valid, out_ready,
    input  rx_ready, out_cmd, out_data, out_valid, kill, drop_cnt, tmo_cnt
  );

  modport slave (
    input  veh_id, rx_byte, rx_valid, out_ready,
    output rx_ready, out_cmd, out_data, out_valid, kill, drop_cnt, tmo_cnt
  );

endinterface

// File: rtl/pkt_fifo.sv
// Show-ahead synchronous FIFO; head entry is presented on dout, zero when empty.
module pkt_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             wr, rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign wr    = push & (~full | pop);
  assign rd    = pop & ~empty;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr && !rd)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (rd && !wr) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/pkt_rx_framer.sv
// Assembles fixed-length frames from a byte stream, filters on destination ID,
// queues accepted frames and latches a sticky broadcast kill.
module pkt_rx_framer
  import pkt_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 4,
  parameter int unsigned PAY_W       = 8 * (FRAME_BYTES - 2),
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic             clk,
  input logic             rst,
  pkt_rx_framer_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(FRAME_BYTES);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  rx_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             own_q, bcast_q;
  logic [7:0]       cmd_q;
  logic [PAY_W-1:0] data_q;
  logic             kill_q;
  logic [7:0]       drop_q, tmo_q;

  logic             hs, final_hs, tmo_fire, is_kill, push_req, kill_set, drop, pop;
  logic             fifo_full, fifo_empty;
  logic [PAY_W+7:0] shifted, head;

  assign hs      = bus.rx_valid;
  assign shifted = {data_q, bus.rx_byte};
  assign pop     = ~fifo_empty & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hs) state_d = ASSM;
      ASSM: begin
        if (hs && idx_q == LAST_IDX)   state_d = IDLE;
        else if (!hs && tmr_q == TMO_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    final_hs = (state_q == ASSM) && hs && (idx_q == LAST_IDX);
    tmo_fire = (state_q == ASSM) && !hs && (tmr_q == TMO_LAST);
    is_kill  = bcast_q && (cmd_q == KILL_CMD);
    kill_set = final_hs && is_kill;
    push_req = final_hs && (own_q || bcast_q) && !is_kill;
    drop     = push_req && fifo_full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      tmr_q   <= '0;
      own_q   <= 1'b0;
      bcast_q <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
      drop_q  <= '0;
      tmo_q   <= '0;
    end else begin
      idx_q <= (state_d == IDLE) ? '0 : (hs ? idx_q + IDX_W'(1) : idx_q);
      tmr_q <= (state_d == IDLE || hs) ? '0 : tmr_q + TMR_W'(1);
      if (state_q == IDLE && hs) begin
        own_q   <= (bus.rx_byte == bus.veh_id);
        bcast_q <= (bus.rx_byte == BCAST_ID);
      end
      if (state_q == ASSM && hs && idx_q == IDX_W'(1)) cmd_q <= bus.rx_byte;
      if (state_q == ASSM && hs && idx_q >= IDX_W'(2)) data_q <= shifted[PAY_W-1:0];
      if (kill_set) kill_q <= 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (tmo_fire && tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
    end
  end

  pkt_fifo #(
    .WIDTH (8 + PAY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   ({cmd_q, shifted[PAY_W-1:0]}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rx_ready  = 1'b1;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_cmd   = head[PAY_W+7:PAY_W];
  assign bus.out_data  = head[PAY_W-1:0];
  assign bus.kill      = kill_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.tmo_cnt   = tmo_q;

endmodule
